rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- T_SETUP, 2: cycles of address/data setup before a strobe.
- T_PULSE, 10: cycles a strobe is held low.
- T_HOLD, 2: cycles after a strobe before the next phase.
- T_GAP, 4: cycles with CS high between transactions.
- All parameters are in the range 1..255.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  transaction request; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched with start.
- addr  in  8  RTC register address; latched with start.
- wdata  in  8  write data; latched with start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  last read data; holds until the next read.
- ChipSelect  out  1  RTC CS#, active low.
- Read  out  1  RTC RD#, active low.
- Write  out  1  RTC WR#, active low.
- AoD  out  1  RTC A/D#: 0 = address phase, 1 = data phase.
- bus_out  out  8  value driven onto DATA_ADDRESS.
- bus_oe  out  1  1 = drive DATA_ADDRESS (the tristate is at top level).
- bus_in  in  8  DATA_ADDRESS as sampled from the pad.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM states SHALL be IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP; an 8-bit down-counter times each state.
REQ-005 IDLE with start=1: latch rw/addr/wdata; go to A_SETUP at the next edge; busy=1 from that cycle.
REQ-006 start while busy=1 SHALL be ignored, with no queueing and no effect on the current transaction.
REQ-007 A_SETUP (T_SETUP cycles): ChipSelect=0, AoD=0, bus_oe=1, bus_out=addr, Read=1, Write=1.
REQ-008 A_STROBE (T_PULSE cycles): same as A_SETUP except Write=0.
REQ-009 A_HOLD (T_HOLD cycles): Write=1; address still driven.
REQ-010 D_SETUP (T_SETUP cycles): AoD=1.
- Write transaction: bus_out=wdata, bus_oe=1.
- Read transaction: bus_oe=0.
REQ-011 D_STROBE (T_PULSE cycles):
- Write transaction: Write=0.
- Read transaction: Read=0; bus_in is captured into rdata on the last D_STROBE cycle.
REQ-012 D_HOLD (T_HOLD cycles): both strobes high; write data still driven.
REQ-013 GAP (T_GAP cycles): ChipSelect=1, bus_oe=0, AoD=0, bus_out=0.
REQ-014 GAP to IDLE: done=1 and busy=0 in the first IDLE cycle; done is high for exactly one cycle.
REQ-015 A start in that same first IDLE cycle SHALL be accepted, allowing back-to-back transactions.
REQ-016 Transaction length from the start-sampling edge to done SHALL be 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles (32 with defaults).
REQ-017 Invariants:
- bus_oe=1 and Read=0 SHALL never hold together.
- Read=0 and Write=0 SHALL never hold together.
- Any strobe low implies ChipSelect=0.
REQ-018 rdata SHALL be unchanged by write transactions.

Reset
REQ-019 reset=0 SHALL immediately force:
- State IDLE, counter 0.
- ChipSelect=1, Read=1, Write=1, AoD=0.
- bus_oe=0, bus_out=0, busy=0, done=0, rdata=0.
REQ-020 Reset mid-transaction SHALL abort it with no done pulse; after reset release, the block is in IDLE and accepts start.

Verification
REQ-021 Write: start, rw=0, addr=0x21, wdata=0x45.
- AoD=0 with bus_out=0x21 while Write is low for 10 cycles.
- Then AoD=1 with bus_out=0x45 while Write is low for 10 cycles.
- done in cycle 32; Read never low.
REQ-022 Read: rw=1, addr=0x22, with the bus model driving bus_in=0x59 during the data strobe.
- rdata=0x59 at done; bus_oe=0 throughout the data phase.
- Write is low only in the address phase.
REQ-023 Busy ignore: pulse start with addr=0x10 at cycle 5 of a write to addr=0x21.
- Only one transaction occurs; addr 0x10 never appears on bus_out.
REQ-024 Back-to-back: start held high continuously.
- Second address phase begins the cycle after done.
- ChipSelect is high for exactly T_GAP+1 cycles between transactions.
REQ-025 Reset abort: reset=0 during D_STROBE of a read.
- Outputs take reset values asynchronously; no done pulse; rdata=0.
- A new write after release completes normally.
REQ-026 Invariant checks: assertions for REQ-017 run in every scenario above, including a parameter set of T_SETUP=1, T_PULSE=1, T_HOLD=1, T_GAP=1 (total 7 cycles).

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// Bus sequencer for a multiplexed-address/data RTC: one address phase, one data phase
// and an inter-transaction gap, each sub-phase timed by a shared 8-bit down-counter.
module rtc_bus_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP
    } state_t;

    localparam logic [7:0] SETUP_M1 = 8'(T_SETUP - 1);
    localparam logic [7:0] PULSE_M1 = 8'(T_PULSE - 1);
    localparam logic [7:0] HOLD_M1  = 8'(T_HOLD - 1);
    localparam logic [7:0] GAP_M1   = 8'(T_GAP - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       rw_q, rw_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] wdata_q, wdata_n;

    logic       busy_n, done_n, cs_n, rd_n, wr_n, aod_n, oe_n;
    logic [7:0] bus_out_n, rdata_n;

    // Next state and counter: each state loads its duration minus one on entry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rw_n    = rw_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        if (state == IDLE) begin
            if (start) begin
                state_n = A_SETUP;
                cnt_n   = SETUP_M1;
                rw_n    = rw;
                addr_n  = addr;
                wdata_n = wdata;
            end
        end else if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
        end else begin
            case (state)
                A_SETUP:  begin state_n = A_STROBE; cnt_n = PULSE_M1; end
                A_STROBE: begin state_n = A_HOLD;   cnt_n = HOLD_M1;  end
                A_HOLD:   begin state_n = D_SETUP;  cnt_n = SETUP_M1; end
                D_SETUP:  begin state_n = D_STROBE; cnt_n = PULSE_M1; end
                D_STROBE: begin state_n = D_HOLD;   cnt_n = HOLD_M1;  end
                D_HOLD:   begin state_n = GAP;      cnt_n = GAP_M1;   end
                default:  begin state_n = IDLE;     cnt_n = 8'd0;     end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        cs_n      = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        aod_n     = 1'b0;
        oe_n      = 1'b0;
        bus_out_n = 8'h00;
        busy_n    = (state_n != IDLE);
        done_n    = (state == GAP) && (cnt == 8'd0);
        rdata_n   = rdata;
        if ((state == D_STROBE) && (cnt == 8'd0) && rw_q)
            rdata_n = bus_in;
        case (state_n)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n      = 1'b0;
                oe_n      = 1'b1;
                bus_out_n = addr_n;
                wr_n      = (state_n != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n  = 1'b0;
                aod_n = 1'b1;
                if (rw_n) begin
                    rd_n = (state_n != D_STROBE);
                end else begin
                    oe_n      = 1'b1;
                    bus_out_n = wdata_n;
                    wr_n      = (state_n != D_STROBE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            rw_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 8'h00;
            ChipSelect <= 1'b1;
            Read       <= 1'b1;
            Write      <= 1'b1;
            AoD        <= 1'b0;
            bus_out    <= 8'h00;
            bus_oe     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rw_q       <= rw_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            busy       <= busy_n;
            done       <= done_n;
            rdata      <= rdata_n;
            ChipSelect <= cs_n;
            Read       <= rd_n;
            Write      <= wr_n;
            AoD        <= aod_n;
            bus_out    <= bus_out_n;
            bus_oe     <= oe_n;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: default timing instance plus a 1/1/1/1 timing instance,
// with bus-protocol invariants checked on every sampled cycle.
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, rw;
    logic [7:0] addr, wdata;
    logic       busy, done, cs, rd, wr, aod, bus_oe;
    logic [7:0] rdata, bus_out, bus_in, bus_val;

    logic       f_start, f_rw;
    logic [7:0] f_addr, f_wdata;
    logic       f_busy, f_done, f_cs, f_rd, f_wr, f_aod, f_bus_oe;
    logic [7:0] f_rdata, f_bus_out, f_bus_in, f_bus_val;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // RTC model: drives the pad only while it sees its read strobe low.
    assign bus_in   = rd   ? 8'h00 : bus_val;
    assign f_bus_in = f_rd ? 8'h00 : f_bus_val;

    rtc_bus_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .ChipSelect(cs), .Read(rd), .Write(wr),
        .AoD(aod), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
        .clk(clk), .reset(reset), .start(f_start), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
        .busy(f_busy), .done(f_done), .rdata(f_rdata), .ChipSelect(f_cs), .Read(f_rd),
        .Write(f_wr), .AoD(f_aod), .bus_out(f_bus_out), .bus_oe(f_bus_oe), .bus_in(f_bus_in)
    );

    // Advance to the next sampling point and check the bus invariants on both instances.
    task automatic tick();
        @(negedge clk);
        checks++;
        if (bus_oe === 1'b1 && rd === 1'b0) begin
            fails++; $display("FAIL inv_oe_rd: bus_oe=%b Read=%b required not both active", bus_oe, rd);
        end
        checks++;
        if (rd === 1'b0 && wr === 1'b0) begin
            fails++; $display("FAIL inv_rd_wr: Read=%b Write=%b required not both low", rd, wr);
        end
        checks++;
        if ((rd === 1'b0 || wr === 1'b0) && cs !== 1'b0) begin
            fails++; $display("FAIL inv_strobe_cs: ChipSelect=%b required 0 with strobe low", cs);
        end
        checks++;
        if (f_bus_oe === 1'b1 && f_rd === 1'b0) begin
            fails++; $display("FAIL fast_inv_oe_rd: bus_oe=%b Read=%b", f_bus_oe, f_rd);
        end
        checks++;
        if (f_rd === 1'b0 && f_wr === 1'b0) begin
            fails++; $display("FAIL fast_inv_rd_wr: Read=%b Write=%b", f_rd, f_wr);
        end
        checks++;
        if ((f_rd === 1'b0 || f_wr === 1'b0) && f_cs !== 1'b0) begin
            fails++; $display("FAIL fast_inv_strobe_cs: ChipSelect=%b required 0", f_cs);
        end
    endtask

    task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] d);
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cs, rd, wr, aod, bus_oe, busy, done} !== 7'b1110000 || bus_out !== 8'h00 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_values: cs/rd/wr/aod/oe/busy/done=%b bus_out=%h rdata=%h required 1110000 00 00",
                     {cs, rd, wr, aod, bus_oe, busy, done}, bus_out, rdata);
        end
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            fails++; $display("FAIL idle_after_release: busy=%b cs=%b required 0 1", busy, cs);
        end
    endtask

    task automatic test_write();
        int aw = 0, dw = 0, rdlow = 0, done_at = -1;
        issue(1'b0, 8'h21, 8'h45);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (n == 0) begin
                checks++;
                if (busy !== 1'b1 || cs !== 1'b0 || aod !== 1'b0 || bus_oe !== 1'b1 || bus_out !== 8'h21) begin
                    fails++;
                    $display("FAIL write_first_cycle: busy=%b cs=%b aod=%b oe=%b bus_out=%h required 1 0 0 1 21",
                             busy, cs, aod, bus_oe, bus_out);
                end
            end
            if (!wr && !aod && bus_out == 8'h21) aw++;
            if (!wr && aod && bus_out == 8'h45) dw++;
            if (!rd) rdlow++;
            if (done) begin done_at = n; break; end
        end
        checks++;
        if (done_at !== 32) begin fails++; $display("FAIL write_done_cycle: got %0d required 32", done_at); end
        checks++;
        if (aw !== 10) begin fails++; $display("FAIL write_addr_strobe: got %0d cycles required 10", aw); end
        checks++;
        if (dw !== 10) begin fails++; $display("FAIL write_data_strobe: got %0d cycles required 10", dw); end
        checks++;
        if (rdlow !== 0) begin fails++; $display("FAIL write_read_low: got %0d cycles required 0", rdlow); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_at_done: got %b required 0", busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL write_done_width: got %b required 0", done); end
    endtask

    task automatic test_read();
        int aw = 0, dw = 0, rdlow = 0, oe_data = 0, done_at = -1;
        bus_val = 8'h59;
        issue(1'b1, 8'h22, 8'h00);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!wr && !aod && bus_out == 8'h22) aw++;
            if (!wr && aod) dw++;
            if (!rd) rdlow++;
            if (aod && bus_oe) oe_data++;
            if (done) begin done_at = n; break; end
        end
        checks++;
        if (done_at !== 32) begin fails++; $display("FAIL read_done_cycle: got %0d required 32", done_at); end
        checks++;
        if (rdata !== 8'h59) begin fails++; $display("FAIL read_rdata: got %h required 59", rdata); end
        checks++;
        if (aw !== 10 || dw !== 0) begin
            fails++; $display("FAIL read_write_strobe: addr=%0d data=%0d required 10 0", aw, dw);
        end
        checks++;
        if (rdlow !== 10) begin fails++; $display("FAIL read_strobe_len: got %0d required 10", rdlow); end
        checks++;
        if (oe_data !== 0) begin fails++; $display("FAIL read_oe_data: got %0d cycles required 0", oe_data); end
    endtask

    task automatic test_busy_ignore();
        int seen10 = 0, done_cnt = 0;
        issue(1'b0, 8'h21, 8'h45);
        for (int n = 0; n < 50; n++) begin
            tick();
            if (n == 5) begin addr = 8'h10; start = 1'b1; end
            if (n == 6) start = 1'b0;
            if (bus_out == 8'h10) seen10++;
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d required 1", done_cnt); end
        checks++;
        if (seen10 !== 0) begin fails++; $display("FAIL ignore_addr10: got %0d cycles required 0", seen10); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ignore_busy_end: got %b required 0", busy); end
        checks++;
        if (rdata !== 8'h59) begin fails++; $display("FAIL write_keeps_rdata: got %h required 59", rdata); end
    endtask

    task automatic test_back_to_back();
        int first_done = -1, second_done = -1, cs_high = 0;
        rw = 1'b0; addr = 8'h30; wdata = 8'h66; start = 1'b1;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (n <= 33 && cs) cs_high++;
            if (done && first_done < 0) first_done = n;
            else if (done) second_done = n;
            if (n == 33) begin
                checks++;
                if (cs !== 1'b0 || aod !== 1'b0 || bus_out !== 8'h30 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_second_addr: cs=%b aod=%b bus_out=%h busy=%b required 0 0 30 1",
                             cs, aod, bus_out, busy);
                end
                start = 1'b0;
            end
        end
        checks++;
        if (first_done !== 32) begin fails++; $display("FAIL b2b_first_done: got %0d required 32", first_done); end
        checks++;
        if (second_done !== 65) begin fails++; $display("FAIL b2b_second_done: got %0d required 65", second_done); end
        checks++;
        if (cs_high !== 5) begin fails++; $display("FAIL b2b_cs_gap: got %0d cycles required 5", cs_high); end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0, done_at = -1;
        bus_val = 8'h77;
        issue(1'b1, 8'h22, 8'h00);
        for (int n = 0; n <= 20; n++) tick();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({cs, rd, wr, aod, bus_oe, busy, done} !== 7'b1110000 || bus_out !== 8'h00 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL abort_async_values: cs/rd/wr/aod/oe/busy/done=%b bus_out=%h rdata=%h required 1110000 00 00",
                     {cs, rd, wr, aod, bus_oe, busy, done}, bus_out, rdata);
        end
        for (int n = 0; n < 3; n++) begin tick(); if (done) done_cnt++; end
        reset = 1'b1;
        for (int n = 0; n < 20; n++) begin tick(); if (done) done_cnt++; end
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0 || rdata !== 8'h00) begin
            fails++; $display("FAIL abort_no_done: done=%0d busy=%b rdata=%h required 0 0 00", done_cnt, busy, rdata);
        end
        issue(1'b0, 8'h55, 8'hAA);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) begin done_at = n; break; end
        end
        checks++;
        if (done_at !== 32) begin fails++; $display("FAIL abort_next_write: got %0d required 32", done_at); end
        checks++;
        if (rdata !== 8'h00) begin fails++; $display("FAIL abort_rdata_after_write: got %h required 00", rdata); end
    endtask

    task automatic test_fast_params();
        int aw = 0, dw = 0, rdlow = 0, done_at = -1;
        f_bus_val = 8'hA5;
        f_rw = 1'b0; f_addr = 8'h12; f_wdata = 8'h34; f_start = 1'b1;
        @(posedge clk);
        #1 f_start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (!f_wr && !f_aod && f_bus_out == 8'h12) aw++;
            if (!f_wr && f_aod && f_bus_out == 8'h34) dw++;
            if (f_done) begin done_at = n; break; end
        end
        checks++;
        if (done_at !== 7) begin fails++; $display("FAIL fast_write_done: got %0d required 7", done_at); end
        checks++;
        if (aw !== 1 || dw !== 1) begin
            fails++; $display("FAIL fast_write_strobes: addr=%0d data=%0d required 1 1", aw, dw);
        end
        done_at = -1;
        f_rw = 1'b1; f_addr = 8'h13; f_start = 1'b1;
        @(posedge clk);
        #1 f_start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (!f_rd) rdlow++;
            if (f_done) begin done_at = n; break; end
        end
        checks++;
        if (done_at !== 7 || f_rdata !== 8'hA5 || rdlow !== 1) begin
            fails++;
            $display("FAIL fast_read: done=%0d rdata=%h rd_low=%0d required 7 a5 1", done_at, f_rdata, rdlow);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_val = 8'h00;
        f_start = 1'b0; f_rw = 1'b0; f_addr = 8'h00; f_wdata = 8'h00; f_bus_val = 8'h00;
        repeat (3) tick();
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_fast_params();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
